haar_window_scheduler: RTL

Cascade controller for the Haar detector. Scans a detection window over the integral image and, for each window position, sequences the shared `haar_classifier_stage` evaluator through stages 0..NUM_STAGES-1 with a start/done handshake. A window is rejected on the first failing stage. Windows that pass every stage are emitted as detections on a valid/ready output. Sits between the frame-level control (start/frame_done) and the single stage datapath, which is time-shared across all stages.

---
 rtl/haar_window_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/haar_window_scheduler.sv
// Cascade controller: rasters a detection window over the integral image and
// time-shares one stage evaluator across all cascade stages of each window.
module haar_window_scheduler #(
  parameter int IMG_WIDTH     = 40,
  parameter int IMG_HEIGHT    = 30,
  parameter int WIN_SIZE      = 20,
  parameter int STEP          = 4,
  parameter int NUM_STAGES    = 3,
  parameter int STAGE_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic        stage_start,
  output logic [7:0]  stage_idx,
  output logic [7:0]  win_x,
  output logic [7:0]  win_y,
  input  logic        stage_done,
  input  logic        stage_pass,
  output logic        det_valid,
  input  logic        det_ready,
  output logic [7:0]  det_x,
  output logic [7:0]  det_y,
  output logic [15:0] win_count,
  output logic [15:0] det_count,
  output logic        timeout_err
);

  localparam int TMO_W = (STAGE_TIMEOUT < 2) ? 1 : $clog2(STAGE_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(STAGE_TIMEOUT - 1);
  localparam logic [8:0]       X_LIM      = 9'(IMG_WIDTH - WIN_SIZE);
  localparam logic [8:0]       Y_LIM      = 9'(IMG_HEIGHT - WIN_SIZE);
  localparam logic [8:0]       STEP9      = 9'(STEP);
  localparam logic [7:0]       LAST_STAGE = 8'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT_WIN,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [8:0]       nx_x;
  logic [8:0]       nx_y;
  logic             x_fits;
  logic             y_fits;
  logic             frame_load;
  logic             stage_adv;
  logic             tmo_hit;
  logic             det_hs;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // 9-bit candidate coordinates so the fit test can never wrap
  assign nx_x   = {1'b0, win_x} + STEP9;
  assign nx_y   = {1'b0, win_y} + STEP9;
  assign x_fits = (nx_x <= X_LIM);
  assign y_fits = (nx_y <= Y_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    frame_load = 1'b0;
    stage_adv  = 1'b0;
    tmo_hit    = 1'b0;
    det_hs     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          frame_load = 1'b1;
          state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        // a result arriving on the expiry cycle takes priority over the timeout
        if (stage_done) begin
          if (!stage_pass) begin
            state_nxt = S_NEXT_WIN;
          end else if (stage_idx >= LAST_STAGE) begin
            state_nxt = S_EMIT;
          end else begin
            stage_adv = 1'b1;
            state_nxt = S_ISSUE;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = S_NEXT_WIN;
        end
      end
      S_EMIT: begin
        if (det_ready) begin
          det_hs    = 1'b1;
          state_nxt = S_NEXT_WIN;
        end
      end
      S_NEXT_WIN: begin
        if (x_fits || y_fits) begin
          state_nxt = S_ISSUE;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_x       <= '0;
      win_y       <= '0;
      stage_idx   <= '0;
      tmo_cnt     <= '0;
      win_count   <= '0;
      det_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (frame_load) begin
        win_x       <= '0;
        win_y       <= '0;
        stage_idx   <= '0;
        win_count   <= '0;
        det_count   <= '0;
        timeout_err <= 1'b0;
      end
      if (state == S_ISSUE) begin
        tmo_cnt <= '0;
      end
      if (state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      if (stage_adv) begin
        stage_idx <= stage_idx + 8'd1;
      end
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end
      if (det_hs) begin
        det_count <= sat_inc(det_count);
      end
      // raster advance; the last window leaves win_x at 0 and win_y at its final row
      if (state == S_NEXT_WIN) begin
        win_count <= sat_inc(win_count);
        stage_idx <= '0;
        if (x_fits) begin
          win_x <= nx_x[7:0];
        end else begin
          win_x <= '0;
          if (y_fits) begin
            win_y <= nx_y[7:0];
          end
        end
      end
    end
  end

  assign busy        = (state != S_IDLE);
  assign stage_start = (state == S_ISSUE);
  assign det_valid   = (state == S_EMIT);
  assign frame_done  = (state == S_DONE);
  assign det_x       = det_valid ? win_x : 8'd0;
  assign det_y       = det_valid ? win_y : 8'd0;

endmodule
